// File: rtl/mux_arb_n.sv
// N-channel valid/ready multiplexer with a registered output stage.
// Channel choice is either a fixed select or round-robin arbitration.
module mux_arb_n #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned BIT_SEL   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mode,
    input  logic [BIT_SEL-1:0]            sel,
    input  logic [NUM_IN*BIT_WIDTH-1:0]   Mux_in,
    input  logic [NUM_IN-1:0]             in_valid,
    output logic [NUM_IN-1:0]             in_ready,
    output logic [BIT_WIDTH-1:0]          Mux_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BIT_SEL-1:0]            out_chan
);

    localparam logic [BIT_SEL-1:0] PTR_RESET = BIT_SEL'(NUM_IN - 1);

    logic [BIT_WIDTH-1:0] chan_data [NUM_IN];
    logic [BIT_SEL-1:0]   rr_ptr;
    logic [BIT_SEL-1:0]   rr_idx;
    logic [BIT_SEL-1:0]   rr_probe;
    logic                 rr_found;
    logic [BIT_SEL-1:0]   fix_idx;
    logic [BIT_SEL-1:0]   cand;
    logic                 cand_valid;
    logic                 load_en;
    logic                 grant;

    // Unpack the flat input bus into per-channel words.
    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign chan_data[g] = Mux_in[g*BIT_WIDTH +: BIT_WIDTH];
    end

    // Round-robin search starts just after the last granted channel.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_probe = '0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            rr_probe = BIT_SEL'((32'(rr_ptr) + k) % NUM_IN);
            if (!rr_found && in_valid[rr_probe]) begin
                rr_found = 1'b1;
                rr_idx   = rr_probe;
            end
        end
    end

    // Out-of-range select falls back to channel 0.
    always_comb begin
        fix_idx = '0;
        if (32'(sel) < NUM_IN) begin
            fix_idx = sel;
        end
    end

    always_comb begin
        cand       = fix_idx;
        cand_valid = in_valid[fix_idx];
        if (mode) begin
            cand       = rr_idx;
            cand_valid = rr_found;
        end
    end

    assign load_en  = !out_valid || out_ready;
    assign grant    = load_en && cand_valid && !reset;
    assign in_ready = grant ? (NUM_IN'(1) << cand) : '0;

    // Output register; an input transfer wins over a plain drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            Mux_out   <= '0;
            out_chan  <= '0;
            rr_ptr    <= PTR_RESET;
        end else begin
            if (grant) begin
                out_valid <= 1'b1;
                Mux_out   <= chan_data[cand];
                out_chan  <= cand;
                if (mode) begin
                    rr_ptr <= cand;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// Randomized and directed bench for mux_arb_n against a queue-free behavioural model.
module tb_mux_arb_n;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int W3 = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mode = 1'b0;
    logic [1:0]    sel = '0;
    logic [N*W-1:0] mux_in = '0;
    logic [N-1:0]  in_valid = '0;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  mux_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_chan;

    logic          mode3 = 1'b0;
    logic [1:0]    sel3 = '0;
    logic [3*W3-1:0] mux_in3 = '0;
    logic [2:0]    iv3 = '0;
    logic [2:0]    ir3;
    logic [W3-1:0] mo3;
    logic          ov3;
    logic          or3 = 1'b0;
    logic [1:0]    oc3;

    int checks = 0;
    int errors = 0;

    bit            mv;
    logic [W-1:0]  md;
    int            mc;
    int            mlast;

    mux_arb_n #(.BIT_WIDTH(W), .NUM_IN(N), .BIT_SEL(2)) u_dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel), .Mux_in(mux_in),
        .in_valid(in_valid), .in_ready(in_ready), .Mux_out(mux_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
    );

    mux_arb_n #(.BIT_WIDTH(W3), .NUM_IN(3), .BIT_SEL(2)) u_dut3 (
        .clk(clk), .reset(reset), .mode(mode3), .sel(sel3), .Mux_in(mux_in3),
        .in_valid(iv3), .in_ready(ir3), .Mux_out(mo3),
        .out_valid(ov3), .out_ready(or3), .out_chan(oc3)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mv    = 1'b0;
        md    = '0;
        mc    = 0;
        mlast = N - 1;
    endtask

    // Which channel should be accepted this cycle, as a one-hot vector.
    function automatic logic [N-1:0] model_grant();
        int c;
        if (mv && !out_ready) return '0;
        if (!mode) begin
            c = (int'(sel) < N) ? int'(sel) : 0;
            return in_valid[c] ? N'(1 << c) : '0;
        end
        for (int k = 1; k <= N; k++) begin
            c = (mlast + k) % N;
            if (in_valid[c]) return N'(1 << c);
        end
        return '0;
    endfunction

    // One clock: check in_ready, advance the model, check the output register.
    task automatic cycle();
        logic [N-1:0] eg;
        int g;
        #1;
        eg = model_grant();
        check("in_ready", 64'(in_ready), 64'(eg));
        @(posedge clk);
        if (eg != '0) begin
            g = 0;
            for (int i = 0; i < N; i++) if (eg[i]) g = i;
            md = mux_in[g*W +: W];
            mc = g;
            mv = 1'b1;
            if (mode) mlast = g;
        end else if (mv && out_ready) begin
            mv = 1'b0;
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(mv));
        check("out_chan", 64'(out_chan), 64'(mc));
        check("mux_out", 64'(mux_out), 64'(md));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data", 64'(mux_out), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check("init_valid", 64'(out_valid), 64'(0));
        check("init_chan", 64'(out_chan), 64'(0));
        check("init_data", 64'(mux_out), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Fixed select of channel 2 with every channel valid.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        mux_in = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
        #1;
        check("fix_ready", 64'(in_ready), 64'(4'b0100));
        cycle();
        check("fix_data", 64'(mux_out), 64'(32'hCAFE0002));
        check("fix_chan", 64'(out_chan), 64'(2));

        // Round-robin rotation from reset.
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mux_in = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            check("rr_seq", 64'(out_chan), 64'(i % 4));
        end

        // Sparse requesters alternate; idle channels never see in_ready.
        do_reset();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_idle", 64'(in_ready & 4'b0101), 64'(0));
            cycle();
            check("rr_alt", 64'(out_chan), 64'((i % 2 == 0) ? 1 : 3));
        end

        // Backpressure holds the word and blocks new grants.
        do_reset();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b0;
        mux_in = {96'h0, 32'h11111111};
        cycle();
        for (int i = 0; i < 3; i++) begin
            mux_in = {96'h0, $urandom};
            #1;
            check("bp_ready", 64'(in_ready), 64'(0));
            cycle();
            check("bp_hold", 64'(mux_out), 64'(32'h11111111));
        end
        out_ready = 1'b1;
        mux_in = {96'h0, 32'h22222222};
        #1;
        check("bp_release", 64'(in_ready), 64'(4'b0001));
        cycle();
        check("bp_new", 64'(mux_out), 64'(32'h22222222));

        // Three-channel instance: out-of-range select maps to channel 0.
        mode3 = 1'b0; sel3 = 2'd3; iv3 = 3'b001; or3 = 1'b1;
        mux_in3 = {8'h33, 8'h22, 8'h11};
        #1;
        check("n3_ready", 64'(ir3), 64'(3'b001));
        @(posedge clk);
        #1;
        check("n3_chan", 64'(oc3), 64'(0));
        check("n3_data", 64'(mo3), 64'(8'h11));
        check("n3_valid", 64'(ov3), 64'(1));
        @(negedge clk);
        iv3 = 3'b100;
        #1;
        check("n3_ignore", 64'(ir3), 64'(0));
        @(negedge clk);

        // Asynchronous reset between edges discards a held word.
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        mux_in = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        check("pre_arst_valid", 64'(out_valid), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_data", 64'(mux_out), 64'(0));
        check("arst_chan", 64'(out_chan), 64'(0));
        check("arst_ready", 64'(in_ready), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("arst_first", 64'(out_chan), 64'(0));

        // Randomized traffic with occasional mode flips and resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            mux_in    = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 149) == 0) do_reset();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter NUM_IN, default 4, number of input channels, legal range 2..16.
REQ-003 SHALL have parameter BIT_SEL, default 2, select/channel-index width, equal to ceil(log2(NUM_IN)).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-007 SHALL have port sel  input  BIT_SEL  channel index used in fixed mode.
REQ-008 SHALL have port Mux_in  input  NUM_IN*BIT_WIDTH  packed channel data; channel i at bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-009 SHALL have port in_valid  input  NUM_IN  per-channel data-valid.
REQ-010 SHALL have port in_ready  output  NUM_IN  per-channel accept strobe.
REQ-011 SHALL have port Mux_out  output  BIT_WIDTH  registered selected data.
REQ-012 SHALL have port out_valid  output  1  Mux_out holds an unconsumed word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-014 SHALL have port out_chan  output  BIT_SEL  index of the channel that sourced Mux_out.

Function
REQ-015 SHALL hold one output register (Mux_out, out_chan, out_valid); load_en = !out_valid | out_ready.
REQ-016 SHALL, in fixed mode, use candidate = sel when sel < NUM_IN, else channel 0.
REQ-017 SHALL, in round-robin mode, pick the first channel with in_valid high, searching from rr_ptr+1 upward, wrapping NUM_IN-1 -> 0.
REQ-018 SHALL assert in_ready[i] combinationally only when load_en is high, i is the candidate and in_valid[i] is high; at most one in_ready bit high per cycle.
REQ-019 SHALL, on an input transfer (in_valid[i] & in_ready[i]), load Mux_in channel i into Mux_out, i into out_chan, set out_valid next cycle: latency 1 cycle.
REQ-020 SHALL clear out_valid on an output transfer (out_valid & out_ready) with no simultaneous input transfer.
REQ-021 SHALL, on simultaneous output and input transfer, replace the register contents and keep out_valid high: sustained throughput 1 word/cycle.
REQ-022 SHALL keep Mux_out, out_chan stable while out_valid & !out_ready.
REQ-023 SHALL update rr_ptr to the granted index only on an input transfer in round-robin mode; fixed-mode transfers leave rr_ptr unchanged.
REQ-024 SHALL apply mode and sel changes at the next arbitration; the word already registered is unaffected.
REQ-025 SHALL, with no valid candidate, assert no in_ready and leave rr_ptr unchanged.
REQ-026 SHALL, in fixed mode, ignore in_valid of non-selected channels (no grant even if selected channel idle).

Reset
REQ-027 SHALL, while reset is high, force out_valid=0, Mux_out=0, out_chan=0, rr_ptr=NUM_IN-1 (channel 0 highest priority first), independent of clk.
REQ-028 SHALL, on reset assertion mid-operation, discard the registered word; in_ready SHALL be 0 while reset is high.
REQ-029 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-030 Fixed mode, NUM_IN=4, sel=2, in_valid=4'b1111, Mux_in ch2=32'hCAFE0002, out_ready=1 -> in_ready=4'b0100; next cycle Mux_out=32'hCAFE0002, out_chan=2, out_valid=1.
REQ-031 Round-robin, all four valid continuously, out_ready=1, from reset -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-032 Round-robin, in_valid=4'b1010 after grant of ch1 -> next grant ch3, then ch1; ch0/ch2 never get in_ready.
REQ-033 Backpressure: out_valid=1, out_ready=0 for 3 cycles, ch0 valid -> in_ready=0, Mux_out/out_chan stable; out_ready=1 -> same-cycle in_ready[0]=1, new word next cycle.
REQ-034 Fixed mode, NUM_IN=3, BIT_SEL=2, sel=3, in_valid=3'b001 -> ch0 granted, out_chan=0.
REQ-035 Reset asserted asynchronously between edges with out_valid=1 -> out_valid, Mux_out, out_chan read 0 immediately; first round-robin grant after release is ch0.
